// File: rtl/scs8hd_crc_pkg.sv
// Shared types and constants for the CRC-8 accumulator slice.
// Holds the FSM encoding and the XOR-network tap generator.
package scs8hd_crc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } crc_state_e;

  localparam logic [7:0] CRC8_POLY_DEFAULT = 8'h07;
  localparam logic [7:0] CRC8_INIT_DEFAULT = 8'h00;

  function automatic logic [7:0] crc8_shift8(
    input logic [7:0] poly,
    input logic [7:0] c
  );
    logic [7:0] r;
    r = c;
    for (int k = 0; k < 8; k++) begin
      if (r[7]) r = {r[6:0], 1'b0} ^ poly;
      else      r = {r[6:0], 1'b0};
    end
    return r;
  endfunction

  // Row bit_i of the linear map x -> shift8(x); bit j set
  // when input bit j feeds output bit bit_i.
  function automatic logic [7:0] crc8_row(
    input logic [7:0] poly,
    input logic [2:0] bit_i
  );
    logic [7:0] row;
    logic [7:0] col;
    row = '0;
    for (int j = 0; j < 8; j++) begin
      col    = crc8_shift8(poly, 8'h01 << j);
      row[j] = col[bit_i];
    end
    return row;
  endfunction

endpackage

// File: rtl/scs8hd_crc8_step.sv
// One-byte CRC-8 update, flattened to a constant-tap XOR network.
// Each output bit is the parity of a fixed subset of (crc_in ^ d).
module scs8hd_crc8_step
  import scs8hd_crc_pkg::*;
#(
  parameter logic [7:0] POLY = CRC8_POLY_DEFAULT
) (
  input  logic [7:0] crc_in,
  input  logic [7:0] d,
  output logic [7:0] crc_out
);

  logic [7:0] x;

  assign x = crc_in ^ d;

  for (genvar i = 0; i < 8; i++) begin : g_bit
    localparam logic [7:0] TAPS =
      crc8_row(POLY, 3'(i));
    assign crc_out[i] = ^(x & TAPS);
  end

endmodule

// File: rtl/scs8hd_crc8_accum.sv
// Framed byte-stream CRC-8 accumulator with residue match flag.
// FSM and registers only; the byte update lives in scs8hd_crc8_step.
module scs8hd_crc8_accum
  import scs8hd_crc_pkg::*;
#(
  parameter logic [7:0] POLY = CRC8_POLY_DEFAULT,
  parameter logic [7:0] INIT = CRC8_INIT_DEFAULT
) (
`ifdef SC_USE_PG_PIN
  input  logic       vpwr,
  input  logic       vgnd,
  input  logic       vpb,
  input  logic       vnb,
`endif
  input  logic       CLK,
  input  logic       RESETB,
  input  logic [7:0] D,
  input  logic       VALID,
  input  logic       SOP,
  input  logic       EOP,
  output logic       READY,
  output logic [7:0] CRC_OUT,
  output logic       CRC_VALID,
  output logic       MATCH,
  output logic       ERR
);

`ifndef SC_USE_PG_PIN
  supply1 vpwr;
  supply0 vgnd;
  supply1 vpb;
  supply0 vnb;
`endif

  crc_state_e state_q;
  logic [7:0] crc_q;
  logic [7:0] crc_out_q;
  logic       crc_valid_q;
  logic       match_q;
  logic       err_q;
  logic       ready_q;

  logic       pwr_ok;
  logic       accept;
  logic [7:0] seed;
  logic [7:0] step;
  logic       drop;
  logic       fin;
  logic       load;
  logic       restart;

  assign pwr_ok = vpwr & ~vgnd & vpb & ~vnb;
  assign accept = VALID & ready_q & pwr_ok;

  // SOP always reseeds, whether opening or restarting a frame.
  assign seed = SOP ? INIT : crc_q;

  scs8hd_crc8_step #(
    .POLY(POLY)
  ) u_step (
    .crc_in (seed),
    .d      (D),
    .crc_out(step)
  );

  always_comb begin
    drop    = (state_q == IDLE) && !SOP;
    fin     = !drop && EOP;
    load    = !drop && !EOP;
    restart = (state_q == ACCUM) && SOP;
  end

  always_ff @(posedge CLK or negedge RESETB) begin
    if (!RESETB) begin
      state_q     <= IDLE;
      crc_q       <= INIT;
      crc_out_q   <= 8'h00;
      crc_valid_q <= 1'b0;
      match_q     <= 1'b0;
      err_q       <= 1'b0;
      ready_q     <= 1'b1;
    end else begin
      crc_valid_q <= 1'b0;
      err_q       <= 1'b0;
      unique case (state_q)
        IDLE, ACCUM: begin
          if (accept) begin
            unique case (1'b1)
              drop: err_q <= 1'b1;
              fin: begin
                crc_out_q   <= step;
                match_q     <= (step == 8'h00);
                crc_valid_q <= 1'b1;
                err_q       <= restart;
                crc_q       <= INIT;
                ready_q     <= 1'b0;
                state_q     <= DONE;
              end
              load: begin
                crc_q   <= step;
                err_q   <= restart;
                state_q <= ACCUM;
              end
            endcase
          end
        end
        DONE: begin
          crc_q   <= INIT;
          ready_q <= 1'b1;
          state_q <= IDLE;
        end
        default: begin
          crc_q   <= INIT;
          ready_q <= 1'b1;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign READY     = ready_q;
  assign CRC_OUT   = crc_out_q;
  assign CRC_VALID = crc_valid_q;
  assign MATCH     = match_q;
  assign ERR       = err_q;

endmodule

// File: tb/tb_scs8hd_crc8_accum.sv
// Scoreboard bench for scs8hd_crc8_accum: driver feeds a bit-serial
// CRC model, monitor pops expectations on CRC_VALID / ERR pulses.
module tb_scs8hd_crc8_accum;

  logic       CLK = 1'b0;
  logic       RESETB = 1'b0;
  logic [7:0] D = 8'h00;
  logic       VALID = 1'b0;
  logic       SOP = 1'b0;
  logic       EOP = 1'b0;
  logic       READY;
  logic [7:0] CRC_OUT;
  logic       CRC_VALID;
  logic       MATCH;
  logic       ERR;

  always #5 CLK = ~CLK;

  scs8hd_crc8_accum dut (
    .CLK      (CLK),
    .RESETB   (RESETB),
    .D        (D),
    .VALID    (VALID),
    .SOP      (SOP),
    .EOP      (EOP),
    .READY    (READY),
    .CRC_OUT  (CRC_OUT),
    .CRC_VALID(CRC_VALID),
    .MATCH    (MATCH),
    .ERR      (ERR)
  );

  typedef struct {
    logic [7:0] crc;
    logic       match;
    int         cyc;
  } exp_t;

  int         checks = 0;
  int         failures = 0;
  int         cyc = 0;
  exp_t       crc_sb[$];
  int         err_sb[$];
  logic [7:0] frame[$];
  bit         in_frame = 0;
  logic [7:0] last_crc = 8'h00;
  int         fixed_exp = -1;
  bit         mon_en = 0;

  always @(posedge CLK) cyc++;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d",
               name, act, exp, cyc);
    end
  endtask

  // Spec-level CRC: bit-serial long division, MSB first.
  function automatic logic [7:0] model_crc(input logic [7:0] b[$]);
    logic [7:0] c;
    logic       fb;
    c = 8'h00;
    foreach (b[i]) begin
      for (int k = 7; k >= 0; k--) begin
        fb = c[7] ^ b[i][k];
        c  = {c[6:0], 1'b0};
        if (fb) c = c ^ 8'h07;
      end
    end
    return c;
  endfunction

  task automatic model_accept(input logic [7:0] d,
                              input bit sop, input bit eop);
    logic [7:0] c;
    if (!in_frame && !sop) begin
      err_sb.push_back(cyc);
      return;
    end
    if (in_frame && sop) err_sb.push_back(cyc);
    if (sop) frame.delete();
    frame.push_back(d);
    in_frame = 1;
    if (eop) begin
      c = model_crc(frame);
      if (fixed_exp >= 0) c = 8'(fixed_exp);
      crc_sb.push_back('{crc: c, match: (c == 8'h00), cyc: cyc});
      in_frame  = 0;
      fixed_exp = -1;
    end
  endtask

  always @(negedge CLK) begin
    exp_t e;
    bit   rdy_exp;
    int   t;
    if (mon_en && RESETB) begin
      rdy_exp = !(crc_sb.size() != 0 && crc_sb[0].cyc == cyc);
      chk("ready", int'(READY), int'(rdy_exp));
      if (crc_sb.size() != 0 && crc_sb[0].cyc < cyc) begin
        e = crc_sb.pop_front();
        chk("crc_valid_missing", 0, 1);
      end
      if (CRC_VALID) begin
        if (crc_sb.size() == 0) begin
          chk("crc_valid_unexpected", 1, 0);
        end else begin
          e = crc_sb.pop_front();
          chk("crc_out", int'(CRC_OUT), int'(e.crc));
          chk("match", int'(MATCH), int'(e.match));
          chk("crc_latency", cyc, e.cyc);
          last_crc = e.crc;
        end
      end else begin
        chk("crc_hold", int'(CRC_OUT), int'(last_crc));
      end
      if (err_sb.size() != 0 && err_sb[0] < cyc) begin
        t = err_sb.pop_front();
        chk("err_missing", 0, 1);
      end
      if (ERR) begin
        if (err_sb.size() == 0) begin
          chk("err_unexpected", 1, 0);
        end else begin
          t = err_sb.pop_front();
          chk("err_latency", cyc, t);
        end
      end
    end
  end

  task automatic send(input logic [7:0] d, input bit sop,
                      input bit eop, input int gap);
    bit acc;
    bit rdy;
    int tries;
    acc   = 0;
    tries = 0;
    repeat (gap) begin
      @(negedge CLK);
      VALID = 1'b0;
      D     = 8'($urandom);
      SOP   = 1'($urandom);
      EOP   = 1'($urandom);
    end
    @(negedge CLK);
    VALID = 1'b1;
    D     = d;
    SOP   = sop;
    EOP   = eop;
    while (!acc) begin
      rdy = READY;
      @(posedge CLK);
      #1;
      if (rdy) begin
        acc = 1;
      end else begin
        tries++;
        if (tries > 8) begin
          chk("accept_timeout", 0, 1);
          break;
        end
        @(negedge CLK);
      end
    end
    VALID = 1'b0;
    if (acc) model_accept(d, sop, eop);
  endtask

  task automatic send_frame(input logic [7:0] b[$],
                            input int gmax, input int fixed);
    int g;
    fixed_exp = fixed;
    foreach (b[i]) begin
      g = (gmax > 0) ? int'($urandom_range(gmax, 0)) : 0;
      send(b[i], i == 0, i == b.size() - 1, g);
    end
  endtask

  initial begin
    logic [7:0] chk_vec[$];
    logic [7:0] fr[$];
    int         len;
    int         rs;

    chk_vec = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35,
                8'h36, 8'h37, 8'h38, 8'h39};

    repeat (3) @(negedge CLK);
    RESETB = 1'b1;
    @(negedge CLK);
    chk("rst_ready", int'(READY), 1);
    chk("rst_crc_out", int'(CRC_OUT), 0);
    chk("rst_crc_valid", int'(CRC_VALID), 0);
    chk("rst_err", int'(ERR), 0);
    chk("rst_match", int'(MATCH), 0);
    mon_en = 1;

    send_frame(chk_vec, 0, 8'hF4);
    send_frame('{8'h01, 8'h07}, 0, 8'h00);
    send_frame('{8'h01}, 0, 8'h07);

    send(8'h5A, 0, 0, 1);
    send(8'hAA, 1, 0, 2);
    send(8'hBB, 0, 0, 0);
    fixed_exp = 8'h07;
    send(8'h01, 1, 1, 0);

    // Two frames back to back: VALID stays up across DONE.
    send_frame('{8'h12, 8'h34, 8'h56}, 0, -1);
    send_frame('{8'h9C, 8'h01}, 0, -1);
    send_frame(chk_vec, 3, 8'hF4);

    for (int f = 0; f < 40; f++) begin
      if ($urandom_range(7, 0) == 0)
        send(8'($urandom), 0, 1'($urandom), 1);
      len = int'($urandom_range(8, 1));
      rs  = ($urandom_range(7, 0) == 0 && len > 1) ?
            int'($urandom_range(len - 1, 1)) : -1;
      for (int i = 0; i < len; i++)
        send(8'($urandom), (i == 0) || (i == rs), i == len - 1,
             ($urandom_range(1, 0) == 0) ? 0 :
             int'($urandom_range(2, 1)));
    end

    send_frame('{8'hE1, 8'h1D, 8'h5B, 8'h77}, 0, -1);
    send(8'h11, 1, 0, 0);
    send(8'h22, 0, 0, 0);
    send(8'h33, 0, 0, 0);
    send(8'h44, 0, 0, 0);
    repeat (3) @(negedge CLK);
    #2;
    RESETB = 1'b0;
    #1;
    chk("arst_ready", int'(READY), 1);
    chk("arst_crc_out", int'(CRC_OUT), 0);
    chk("arst_crc_valid", int'(CRC_VALID), 0);
    chk("arst_match", int'(MATCH), 0);
    chk("arst_err", int'(ERR), 0);
    frame.delete();
    in_frame = 0;
    last_crc = 8'h00;
    @(negedge CLK);
    @(negedge CLK);
    RESETB = 1'b1;
    send_frame('{8'h01}, 0, 8'h07);

    repeat (4) @(negedge CLK);
    chk("crc_sb_drained", crc_sb.size(), 0);
    chk("err_sb_drained", err_sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
